// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: watches the four coil wires of a half-step stepper
// drive and reconstructs the motion: step pulses, direction, signed position,
// hold timeout and sticky fault flags.
// Optional rate measurement (steps per WINDOW clocks) is compiled in when the
// macro STEP_SPEED_EN is defined. Otherwise speed and speed_valid are tied to 0.
module stepper_phase_decoder #(
   parameter int CNT_W       = 16,
   parameter int SPD_W       = 8,
   parameter int WINDOW      = 1000,
   parameter int HOLD_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       sem,
   input  logic             clear,
   output logic             step_pulse,
   output logic             dir,
   output logic [CNT_W-1:0] position,
   output logic [SPD_W-1:0] speed,
   output logic             speed_valid,
   output logic             hold_timeout,
   output logic             err_illegal,
   output logic             err_skip
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   logic [3:0]       s1_q, s2_q;
   logic [2:0]       prev_phase_q, prev_phase_d;
   logic             prev_valid_q, prev_valid_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic             ill_q, ill_d;
   logic             skip_q, skip_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic       legal;
   logic [2:0] phase;
   logic [2:0] delta;
   logic       hold_inc, hold_clr;

   // Two-flop synchronizer for the asynchronous coil wires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= sem;
         s2_q <= s1_q;
      end
   end

   // Map a synchronized coil pattern onto its half-step phase index.
   always_comb begin
      legal = 1'b1;
      phase = 3'd0;
      case (s2_q)
         4'b0001: phase = 3'd0;
         4'b0011: phase = 3'd1;
         4'b0010: phase = 3'd2;
         4'b0110: phase = 3'd3;
         4'b0100: phase = 3'd4;
         4'b1100: phase = 3'd5;
         4'b1000: phase = 3'd6;
         4'b1001: phase = 3'd7;
         default: legal = 1'b0;
      endcase
      delta = phase - prev_phase_q;
   end

   // Step decision, position update, fault flags and hold-timer control.
   always_comb begin
      prev_phase_d = prev_phase_q;
      prev_valid_d = prev_valid_q;
      step_d       = 1'b0;
      dir_d        = dir_q;
      pos_d        = pos_q;
      ill_d        = ill_q;
      skip_d       = skip_q;
      hold_inc     = 1'b0;
      hold_clr     = 1'b0;
      if (clear) begin
         pos_d        = '0;
         ill_d        = 1'b0;
         skip_d       = 1'b0;
         prev_valid_d = 1'b0;
         hold_clr     = 1'b1;
      end else if (s2_q == 4'b0000) begin
         // Idle coils: keep the last phase so motion resumes seamlessly.
         hold_clr = 1'b1;
      end else if (!legal) begin
         ill_d        = 1'b1;
         prev_valid_d = 1'b0;
         hold_clr     = 1'b1;
      end else if (!prev_valid_q) begin
         // First legal pattern only anchors the phase reference.
         prev_phase_d = phase;
         prev_valid_d = 1'b1;
         hold_inc     = 1'b1;
      end else begin
         case (delta)
            3'd0: hold_inc = 1'b1;
            3'd1: begin
               step_d       = 1'b1;
               dir_d        = 1'b1;
               pos_d        = pos_q + 1'b1;
               prev_phase_d = phase;
               hold_clr     = 1'b1;
            end
            3'd7: begin
               step_d       = 1'b1;
               dir_d        = 1'b0;
               pos_d        = pos_q - 1'b1;
               prev_phase_d = phase;
               hold_clr     = 1'b1;
            end
            default: begin
               skip_d       = 1'b1;
               prev_phase_d = phase;
               hold_inc     = 1'b1;
            end
         endcase
      end
      hold_d = hold_q;
      if (hold_clr) begin
         hold_d = '0;
      end else if (hold_inc && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_phase_q <= '0;
         prev_valid_q <= 1'b0;
         step_q       <= 1'b0;
         dir_q        <= 1'b0;
         pos_q        <= '0;
         ill_q        <= 1'b0;
         skip_q       <= 1'b0;
         hold_q       <= '0;
      end else begin
         prev_phase_q <= prev_phase_d;
         prev_valid_q <= prev_valid_d;
         step_q       <= step_d;
         dir_q        <= dir_d;
         pos_q        <= pos_d;
         ill_q        <= ill_d;
         skip_q       <= skip_d;
         hold_q       <= hold_d;
      end
   end

   assign step_pulse   = step_q;
   assign dir          = dir_q;
   assign position     = pos_q;
   assign err_illegal  = ill_q;
   assign err_skip     = skip_q;
   assign hold_timeout = (hold_q == HOLD_MAX);

`ifdef STEP_SPEED_EN
   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   logic [WIN_W-1:0] win_q, win_d;
   logic [SPD_W-1:0] stp_q, stp_d, stp_sum;
   logic [SPD_W-1:0] speed_q, speed_d;
   logic             sv_q, sv_d;

   // Window counter and saturating step count; a step decoded on the last
   // window cycle is still included in the published rate.
   always_comb begin
      stp_sum = (stp_q == {SPD_W{1'b1}}) ? stp_q : stp_q + SPD_W'(step_d);
      win_d   = win_q + 1'b1;
      stp_d   = stp_sum;
      speed_d = speed_q;
      sv_d    = 1'b0;
      if (clear) begin
         win_d = '0;
         stp_d = '0;
      end else if (win_q == WIN_LAST) begin
         speed_d = stp_sum;
         sv_d    = 1'b1;
         win_d   = '0;
         stp_d   = '0;
      end
   end

   // Rate measurement registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q   <= '0;
         stp_q   <= '0;
         speed_q <= '0;
         sv_q    <= 1'b0;
      end else begin
         win_q   <= win_d;
         stp_q   <= stp_d;
         speed_q <= speed_d;
         sv_q    <= sv_d;
      end
   end

   assign speed       = speed_q;
   assign speed_valid = sv_q;
`else
   assign speed       = '0;
   assign speed_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Self-checking bench for stepper_phase_decoder: directed scenarios plus a
// randomized segment, compared against a behavioural model of the decoder.
module tb_stepper_phase_decoder;

   localparam int CNT_W = 16;
   localparam int SPD_W = 8;
   localparam int HOLD  = 4096;
   localparam int W1    = 100;
   localparam int W2    = 400;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic [3:0] sem;

   logic             step_pulse, dir, speed_valid, hold_timeout, err_illegal, err_skip;
   logic [CNT_W-1:0] position;
   logic [SPD_W-1:0] speed;
   logic             step_pulse2, dir2, speed_valid2, hold_timeout2, err_illegal2, err_skip2;
   logic [CNT_W-1:0] position2;
   logic [SPD_W-1:0] speed2;

   always #5 clk = ~clk;

   stepper_phase_decoder #(.CNT_W(CNT_W), .SPD_W(SPD_W), .WINDOW(W1), .HOLD_CYCLES(HOLD)) u_dut (
      .clk(clk), .rst(rst), .sem(sem), .clear(clear),
      .step_pulse(step_pulse), .dir(dir), .position(position), .speed(speed),
      .speed_valid(speed_valid), .hold_timeout(hold_timeout),
      .err_illegal(err_illegal), .err_skip(err_skip));

   // Second instance with a long window, used to see the rate saturate.
   stepper_phase_decoder #(.CNT_W(CNT_W), .SPD_W(SPD_W), .WINDOW(W2), .HOLD_CYCLES(HOLD)) u_dut2 (
      .clk(clk), .rst(rst), .sem(sem), .clear(clear),
      .step_pulse(step_pulse2), .dir(dir2), .position(position2), .speed(speed2),
      .speed_valid(speed_valid2), .hold_timeout(hold_timeout2),
      .err_illegal(err_illegal2), .err_skip(err_skip2));

   int tests = 0;
   int fails = 0;

   logic [3:0] SEQ [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                           4'b0100, 4'b1100, 4'b1000, 4'b1001};
   int WIN [2] = '{W1, W2};

   // ---------------- behavioural model ----------------
   logic [3:0] h1, h2, m_dec;
   int  m_prev, m_ph, m_d;
   bit  m_pv, m_step, m_dir, m_ill, m_skip;
   int  m_pos, m_hold;
   int  m_win [2];
   int  m_cnt [2];
   int  m_speed [2];
   bit  m_sv [2];

   function automatic int phase_of(input logic [3:0] p);
      for (int i = 0; i < 8; i++) if (SEQ[i] == p) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         h1 = 0; h2 = 0; m_prev = 0; m_pv = 0; m_step = 0; m_dir = 0;
         m_ill = 0; m_skip = 0; m_pos = 0; m_hold = 0;
         for (int k = 0; k < 2; k++) begin
            m_win[k] = 0; m_cnt[k] = 0; m_speed[k] = 0; m_sv[k] = 0;
         end
      end else begin
         // pattern reaching the decoder is the one sampled two edges ago
         m_dec = h2; h2 = h1; h1 = sem;
         m_step = 0;
         if (clear) begin
            m_pos = 0; m_ill = 0; m_skip = 0; m_pv = 0; m_hold = 0;
         end else begin
            m_ph = phase_of(m_dec);
            if (m_dec == 4'b0000) m_hold = 0;
            else if (m_ph < 0) begin m_ill = 1; m_pv = 0; m_hold = 0; end
            else if (!m_pv) begin
               m_prev = m_ph; m_pv = 1;
               if (m_hold < HOLD) m_hold++;
            end else begin
               m_d = (m_ph - m_prev + 8) % 8;
               if (m_d == 1 || m_d == 7) begin
                  m_step = 1; m_dir = (m_d == 1);
                  m_pos = m_pos + ((m_d == 1) ? 1 : -1);
                  m_hold = 0;
               end else begin
                  if (m_d != 0) m_skip = 1;
                  if (m_hold < HOLD) m_hold++;
               end
               m_prev = m_ph;
            end
         end
`ifdef STEP_SPEED_EN
         for (int k = 0; k < 2; k++) begin
            m_sv[k] = 0;
            if (clear) begin m_win[k] = 0; m_cnt[k] = 0; end
            else if (m_win[k] == WIN[k] - 1) begin
               m_cnt[k] += int'(m_step);
               m_speed[k] = (m_cnt[k] > 255) ? 255 : m_cnt[k];
               m_sv[k] = 1; m_win[k] = 0; m_cnt[k] = 0;
            end else begin
               m_win[k]++; m_cnt[k] += int'(m_step);
            end
         end
`endif
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [63:0] o, e;
      o = {25'd0, step_pulse, dir, position, hold_timeout, err_illegal, err_skip,
           speed, speed_valid, speed2, speed_valid2};
      e = {25'd0, m_step, m_dir, 16'(m_pos), (m_hold == HOLD), m_ill, m_skip,
           8'(m_speed[0]), m_sv[0], 8'(m_speed[1]), m_sv[1]};
      chk(tag, o, e);
   endtask

   task automatic drive(input logic [3:0] p, input int n);
      sem = p;
      repeat (n) begin @(negedge clk); chk_model("model"); end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int steps, n, pulses, pulse_at, cur, r, len;
      rst = 1'b0; sem = 4'b0000; clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {step_pulse, dir, position, speed, speed_valid,
                            hold_timeout, err_illegal, err_skip}, 0);
      rst = 1'b1;

      // forward sequence
      steps = 0;
      for (int i = 0; i < 4; i++) begin
         sem = SEQ[i];
         repeat (10) begin @(negedge clk); steps += int'(step_pulse); chk_model("fwd_model"); end
      end
      chk("fwd_steps", steps, 3);
      chk("fwd_dir", dir, 1);
      chk("fwd_pos", position, 3);
      chk("fwd_errs", {err_illegal, err_skip}, 0);

      // reverse through zero
      pulse_clear();
      drive(4'b0001, 5); drive(4'b1001, 5); drive(4'b1000, 5);
      chk("rev_pos", position, 16'hFFFE);
      chk("rev_dir", dir, 0);

      // fast forward run up to 0x7FFF, then wrap
      pulse_clear();
      drive(4'b0001, 5);
      for (int k = 1; k <= 32767; k++) begin
         sem = SEQ[k % 8];
         @(negedge clk);
         if (k == 32000) begin
`ifdef STEP_SPEED_EN
            chk("speed_full_window", speed, W1);
            chk("speed_saturated", speed2, 255);
`else
            chk("speed_tied_low", {speed, speed2}, 0);
`endif
         end
      end
      repeat (4) @(negedge clk);
      chk("pos_max", position, 16'h7FFF);
      chk_model("pos_max_model");
      drive(SEQ[0], 5);
      chk("pos_wrap", position, 16'h8000);
      chk("wrap_dir", dir, 1);

      // illegal pattern, re-anchor, skip, sticky flags
      pulse_clear();
      drive(4'b0001, 5);
      drive(4'b0101, 5);
      chk("illegal_flag", err_illegal, 1);
      chk("illegal_pos", position, 0);
      steps = 0;
      sem = 4'b0011;
      repeat (5) begin @(negedge clk); steps += int'(step_pulse); end
      chk("reanchor_nostep", steps, 0);
      drive(4'b0001, 5);
      chk("reanchor_then_rev", position, 16'hFFFF);
      drive(4'b0110, 10);
      chk("skip_flag", err_skip, 1);
      chk("skip_pos", position, 16'hFFFF);
      chk("flags_sticky", {err_illegal, err_skip}, 2'b11);
      pulse_clear();
      chk("flags_cleared", {err_illegal, err_skip, position}, 0);

      // hold timeout timing and idle behaviour
      drive(4'b0000, 4);
      sem = 4'b0011;
      n = 0;
      while (n < 5000) begin
         @(negedge clk); n++;
         if (hold_timeout) break;
      end
      chk("hold_rise_cycle", n, 4098);
      sem = 4'b0000;
      repeat (2) @(negedge clk);
      chk("hold_still_high", hold_timeout, 1);
      @(negedge clk);
      chk("hold_dropped", hold_timeout, 0);
      drive(4'b0000, 3);
      drive(4'b0001, 5);
      chk("idle_rev_pos", position, 16'hFFFF);
      chk("idle_rev_dir", dir, 0);

      // clear coinciding with a decoded step
      sem = 4'b0011;
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_step_dropped", {step_pulse, position}, 0);
      chk("clr_keeps_dir", dir, 0);
      drive(4'b0011, 4);
      chk("clr_reanchor", position, 0);

      // rate window: 7 steps within one window
      drive(4'b0000, 3);
      pulse_clear();
      pulses = 0; pulse_at = 0;
      for (int i = 1; i <= 110; i++) begin
         cur = i / 5;
         if (cur > 7) cur = 7;
         sem = SEQ[cur];
         @(negedge clk);
         chk_model("win_model");
         if (speed_valid) begin pulses++; pulse_at = i; end
      end
      chk("win_pos", position, 7);
`ifdef STEP_SPEED_EN
      chk("win_pulses", pulses, 1);
      chk("win_pulse_at", pulse_at, W1);
      chk("win_speed", speed, 7);
`else
      chk("win_pulses", pulses, 0);
`endif

      // randomized walk, checked against the model each cycle
      cur = 7;
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 19);
         len = $urandom_range(1, 4);
         if (r <= 5)       begin cur = (cur + 1) % 8; sem = SEQ[cur]; end
         else if (r <= 10) begin cur = (cur + 7) % 8; sem = SEQ[cur]; end
         else if (r <= 12) begin cur = (cur + $urandom_range(2, 6)) % 8; sem = SEQ[cur]; end
         else if (r <= 14) sem = 4'b0000;
         else if (r == 15) sem = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b1111;
         else if (r == 16) clear = 1'b1;
         repeat (len) begin
            @(negedge clk);
            chk_model("rand_model");
            clear = 1'b0;
         end
      end

      // asynchronous reset in the middle of motion
      pulse_clear();
      drive(SEQ[0], 4); drive(SEQ[1], 4); drive(SEQ[2], 4);
      chk("pre_reset_pos", position, 2);
      #2 rst = 1'b0;
      #1;
      chk("async_reset", {step_pulse, dir, position, speed, speed_valid,
                          hold_timeout, err_illegal, err_skip}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
